// File: rtl/decoder.sv
// Instruction decoder: combinational field slicing plus a one-cycle
// registered decode (ALU select, write-back control, immediate).
// Optional feature macro: DECODER_EXT_OPS_EN adds SUB/AND/OR/SLT R-type
// decoding by function code and the ANDI/ORI immediate opcodes.
module decoder (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] IC,
  input  logic        Vld,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sh,
  output logic [5:0]  fn,
  output logic        VldQ,
  output logic [3:0]  AluOp,
  output logic        WrEn,
  output logic [4:0]  WrReg,
  output logic        UseImm,
  output logic [31:0] ImmSx,
  output logic        Illegal
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_NOP = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  // Field slices are pure wiring: no latency, independent of reset.
  assign op = IC[31:26];
  assign rs = IC[25:21];
  assign rt = IC[20:16];
  assign rd = IC[15:11];
  assign sh = IC[10:6];
  assign fn = IC[5:0];

  logic [3:0]  w_alu;
  logic        w_wr;      // instruction writes a register (before r0 filter)
  logic [4:0]  w_wrreg;
  logic        w_useimm;
  logic [31:0] w_imm;
  logic        w_ill;

  logic        r_vldq;
  logic [3:0]  r_alu;
  logic        r_wren;
  logic [4:0]  r_wrreg;
  logic        r_useimm;
  logic [31:0] r_imm;
  logic        r_ill;

  // Decode the current word; unsupported words fall through to the defaults.
  always_comb begin
    w_alu    = ALU_NOP;
    w_wr     = 1'b0;
    w_wrreg  = 5'd0;
    w_useimm = 1'b0;
    w_imm    = {{16{IC[15]}}, IC[15:0]};
    w_ill    = 1'b1;
    case (op)
      OP_RTYPE: begin
`ifdef DECODER_EXT_OPS_EN
        w_ill = 1'b0;
        case (fn)
          6'h20:   w_alu = ALU_ADD;
          6'h22:   w_alu = ALU_SUB;
          6'h24:   w_alu = ALU_AND;
          6'h25:   w_alu = ALU_OR;
          6'h2A:   w_alu = ALU_SLT;
          default: w_ill = 1'b1;
        endcase
        if (!w_ill) begin
          w_wr    = 1'b1;
          w_wrreg = rd;
        end
`else
        w_alu   = ALU_ADD;
        w_wr    = 1'b1;
        w_wrreg = rd;
        w_ill   = 1'b0;
`endif
      end
      OP_ADDI: begin
        w_alu    = ALU_ADD;
        w_wr     = 1'b1;
        w_wrreg  = rt;
        w_useimm = 1'b1;
        w_ill    = 1'b0;
      end
`ifdef DECODER_EXT_OPS_EN
      OP_ANDI, OP_ORI: begin
        w_alu    = (op == OP_ANDI) ? ALU_AND : ALU_OR;
        w_wr     = 1'b1;
        w_wrreg  = rt;
        w_useimm = 1'b1;
        w_imm    = {16'd0, IC[15:0]};
        w_ill    = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  // Registered decode: reset wins over Vld; Vld=0 holds the last decode.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_vldq   <= 1'b0;
      r_alu    <= ALU_NOP;
      r_wren   <= 1'b0;
      r_wrreg  <= 5'd0;
      r_useimm <= 1'b0;
      r_imm    <= 32'd0;
      r_ill    <= 1'b0;
    end else begin
      r_vldq <= Vld;
      if (Vld) begin
        r_alu    <= w_alu;
        r_wren   <= w_wr && (w_wrreg != 5'd0);  // writes to r0 are dropped
        r_wrreg  <= w_wrreg;
        r_useimm <= w_useimm;
        r_imm    <= w_imm;
        r_ill    <= w_ill;
      end
    end
  end

  assign VldQ    = r_vldq;
  assign AluOp   = r_alu;
  assign WrEn    = r_wren;
  assign WrReg   = r_wrreg;
  assign UseImm  = r_useimm;
  assign ImmSx   = r_imm;
  assign Illegal = r_ill;

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: each driven cycle pushes the expected
// registered outputs; they are popped and compared one Clk later.
module tb_decoder;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] IC;
  logic        Vld;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, sh;
  logic [5:0]  fn;
  logic        VldQ;
  logic [3:0]  AluOp;
  logic        WrEn;
  logic [4:0]  WrReg;
  logic        UseImm;
  logic [31:0] ImmSx;
  logic        Illegal;

  decoder dut (
    .Clk(Clk), .Rst(Rst), .IC(IC), .Vld(Vld),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .sh(sh), .fn(fn),
    .VldQ(VldQ), .AluOp(AluOp), .WrEn(WrEn), .WrReg(WrReg),
    .UseImm(UseImm), .ImmSx(ImmSx), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        vldq;
    logic [3:0]  alu;
    logic        wren;
    logic [4:0]  wrreg;
    logic        useimm;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t model_st;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference decode written as a lookup against the instruction table.
  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    logic [5:0] o = w[31:26];
    logic [5:0] f = w[5:0];
    logic       ok = 1'b0;
    logic [4:0] dst = 5'd0;
    logic [3:0] a = 4'd15;
    logic       im = 1'b0;
    logic [31:0] x = {{16{w[15]}}, w[15:0]};
    if (o == 6'd0) begin
`ifdef DECODER_EXT_OPS_EN
      ok = 1'b1;
      if      (f == 6'h20) a = 4'd0;
      else if (f == 6'h22) a = 4'd1;
      else if (f == 6'h24) a = 4'd2;
      else if (f == 6'h25) a = 4'd3;
      else if (f == 6'h2A) a = 4'd4;
      else ok = 1'b0;
`else
      ok = 1'b1; a = 4'd0;
`endif
      if (ok) dst = w[15:11];
      else    a = 4'd15;
    end else if (o == 6'd8) begin
      ok = 1'b1; a = 4'd0; im = 1'b1; dst = w[20:16];
`ifdef DECODER_EXT_OPS_EN
    end else if (o == 6'h0C || o == 6'h0D) begin
      ok = 1'b1; a = (o == 6'h0C) ? 4'd2 : 4'd3; im = 1'b1; dst = w[20:16];
      x = {16'h0000, w[15:0]};
`endif
    end
    e.vldq   = 1'b1;
    e.alu    = a;
    e.wren   = ok && (dst != 5'd0);
    e.wrreg  = dst;
    e.useimm = im;
    e.imm    = x;
    e.ill    = !ok;
    return e;
  endfunction

  // One clock of stimulus: drive, check slices, predict, then compare regs.
  task automatic step(input logic rst, input logic vld, input logic [31:0] w);
    exp_t e;
    @(negedge Clk);
    Rst = rst; Vld = vld; IC = w;
    #1;
    chk("op", {26'd0, op}, {26'd0, w[31:26]});
    chk("rs_rt", {22'd0, rs, rt}, {22'd0, w[25:16]});
    chk("rd_sh_fn", {16'd0, rd, sh, fn}, {16'd0, w[15:0]});
    if (rst) begin
      model_st = '{vldq:1'b0, alu:4'd15, wren:1'b0, wrreg:5'd0, useimm:1'b0, imm:32'd0, ill:1'b0};
    end else if (vld) begin
      model_st = ref_dec(w);
    end else begin
      model_st.vldq = 1'b0;
    end
    sb_q.push_back(model_st);
    @(posedge Clk);
    #1;
    e = sb_q.pop_front();
    chk("VldQ",    {31'd0, VldQ},    {31'd0, e.vldq});
    chk("AluOp",   {28'd0, AluOp},   {28'd0, e.alu});
    chk("WrEn",    {31'd0, WrEn},    {31'd0, e.wren});
    chk("WrReg",   {27'd0, WrReg},   {27'd0, e.wrreg});
    chk("UseImm",  {31'd0, UseImm},  {31'd0, e.useimm});
    chk("ImmSx",   ImmSx,            e.imm);
    chk("Illegal", {31'd0, Illegal}, {31'd0, e.ill});
  endtask

  initial begin
    logic [31:0] w;
    Rst = 1'b1; Vld = 1'b0; IC = 32'd0;
    model_st = '0;
    // Reset with a valid word present: word discarded, reset values seen.
    step(1'b1, 1'b1, 32'h012A4020);
    chk("rst_alu_nop", {28'd0, AluOp}, 32'd15);
    // Hold across three idle cycles after reset.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'hDEADBEEF);

    // R-type ADD, slices checked in-cycle, decode one clock later.
    step(1'b0, 1'b1, 32'h012A4020);
    chk("rtype_wrreg", {27'd0, WrReg}, 32'd8);
    // ADDI with negative immediate.
    step(1'b0, 1'b1, 32'h2109FFFF);
    chk("addi_imm", ImmSx, 32'hFFFFFFFF);
    // Unsupported opcode.
    step(1'b0, 1'b1, 32'hFC000000);
    chk("illegal_flag", {31'd0, Illegal}, 32'd1);
    // ADDI to r0: write suppressed, not illegal.
    step(1'b0, 1'b1, 32'h20000005);
    chk("r0_wren", {31'd0, WrEn}, 32'd0);
    chk("r0_imm", ImmSx, 32'd5);
    // Hold after a valid decode.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h12345678);
    // SUB funct: behaviour depends on the build option.
    step(1'b0, 1'b1, 32'h012A4022);
`ifdef DECODER_EXT_OPS_EN
    chk("sub_variant", {28'd0, AluOp}, 32'd1);
`else
    chk("sub_variant", {28'd0, AluOp}, 32'd0);
`endif
    // Back-to-back valid words: AND, OR, SLT, odd funct, R-type to r0, ANDI, ORI.
    step(1'b0, 1'b1, 32'h012A4024);
    step(1'b0, 1'b1, 32'h012A4025);
    step(1'b0, 1'b1, 32'h012A402A);
    step(1'b0, 1'b1, 32'h012A4021);
    step(1'b0, 1'b1, 32'h012A0020);
    step(1'b0, 1'b1, 32'h31288000);
    step(1'b0, 1'b1, 32'h3528FFFF);
    // Mid-stream reset, then random traffic with random gaps.
    step(1'b1, 1'b0, 32'h2109FFFF);
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      case (i % 4)
        0: w[31:26] = 6'h00;
        1: w[31:26] = 6'h08;
        2: w[31:26] = 6'h0C + 6'($urandom_range(0, 1));
        default: ;
      endcase
      step(1'b0, 1'($urandom_range(0, 3) != 0), w);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
